// File: rtl/xor_serial_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : xor_serial_ctrl (with helper cell xor_1b)              |
// | Description : Bit-serial XOR engine controller. Streams two WIDTH-bit |
// |               operands LSB-first through one shared 1-bit XOR cell    |
// |               and presents the assembled result over valid/ready.     |
// | Option      : define XOR_PARITY_EN to add a running-parity output.    |
// | Revision    : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+

// Single-bit XOR cell built from AND/OR terms; shared by the controller.
module xor_1b (
  input  logic A,
  input  logic B,
  output logic C
);
  assign C = (A & ~B) | (~A & B);
endmodule

module xor_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             busy
`ifdef XOR_PARITY_EN
  ,
  output logic             parity
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_run  = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_res;
  logic [CNT_W-1:0] r_cnt;
  logic             w_bit;

  // The one shared XOR cell always sees the current LSBs of the operands.
  xor_1b u_xor_data (
    .A (r_sa[0]),
    .B (r_sb[0]),
    .C (w_bit)
  );

  // Handshake flags decode purely from state, so in_ready never depends
  // combinationally on in_valid.
  assign in_ready  = (r_state == c_st_idle);
  assign out_valid = (r_state == c_st_done);
  assign busy      = (r_state != c_st_idle);
  assign c         = r_res;

`ifdef XOR_PARITY_EN
  logic r_par;
  logic w_par_nxt;

  // Second cell folds each new result bit into the running parity.
  xor_1b u_xor_par (
    .A (r_par),
    .B (w_bit),
    .C (w_par_nxt)
  );

  assign parity = r_par;

  // Parity accumulator: cleared on acceptance, updated every RUN cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_par <= 1'b0;
    end else if (r_state == c_st_idle && in_valid) begin
      r_par <= 1'b0;
    end else if (r_state == c_st_run) begin
      r_par <= w_par_nxt;
    end
  end
`endif

  // Sequencer: capture operands, shift WIDTH bits through the cell, then
  // hold the result until the consumer takes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
      r_sa    <= '0;
      r_sb    <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (in_valid) begin
            r_sa    <= a;
            r_sb    <= b;
            r_cnt   <= '0;
            r_state <= c_st_run;
          end
        end
        c_st_run: begin
          // Result enters at the MSB and moves right; after WIDTH shifts
          // bit i sits in position i.
          r_res <= {w_bit, r_res[WIDTH-1:1]};
          r_sa  <= r_sa >> 1;
          r_sb  <= r_sb >> 1;
          if (r_cnt == c_last) begin
            r_state <= c_st_done;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        c_st_done: begin
          if (out_ready) begin
            r_state <= c_st_idle;
          end
        end
        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
